// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - sequential Booth multiplier with valid/ready handshakes
// Radix-2 recoding by default; define BOOTH_RADIX4_EN for radix-4 recoding (N must be even).
module booth_mult_seq #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             tc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   y
);

`ifdef BOOTH_RADIX4_EN
  localparam int W     = N + 2;
  localparam int STEPS = W / 2;
  localparam int SH    = 2;
`else
  localparam int W     = N + 1;
  localparam int STEPS = W;
  localparam int SH    = 1;
`endif
  localparam int AW = W + 1;
  localparam int SW = AW + W + 1;
  localparam int CW = $clog2(STEPS + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     m_q, m_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [W-1:0]     q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*N-1:0]   y_q, y_d;

  logic [AW-1:0]    m_sx;
  logic [AW-1:0]    sum;
  logic signed [SW-1:0] shifted;

  assign m_sx = {m_q[W-1], m_q};

`ifdef BOOTH_RADIX4_EN
  logic [AW-1:0] m2;
  assign m2 = {m_q, 1'b0};

  always_comb begin
    sum = acc_q;
    case ({q_q[1:0], qm1_q})
      3'b001, 3'b010: sum = acc_q + m_sx;
      3'b011:         sum = acc_q + m2;
      3'b100:         sum = acc_q - m2;
      3'b101, 3'b110: sum = acc_q - m_sx;
      default:        sum = acc_q;
    endcase
  end
`else
  always_comb begin
    sum = acc_q;
    case ({q_q[0], qm1_q})
      2'b01:   sum = acc_q + m_sx;
      2'b10:   sum = acc_q - m_sx;
      default: sum = acc_q;
    endcase
  end
`endif

  // Arithmetic shift of the whole {acc,Q,Q_-1} chain keeps the partial product's sign.
  assign shifted = $signed({sum, q_q, qm1_q}) >>> SH;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d     = {{(W-N){tc & a[N-1]}}, a};
          q_d     = {{(W-N){tc & b[N-1]}}, b};
          acc_d   = '0;
          qm1_d   = 1'b0;
          cnt_d   = CW'(STEPS);
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = shifted[SW-1:W+1];
        q_d   = shifted[W:1];
        qm1_d = shifted[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          y_d     = shifted[2*N:1];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign y         = y_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb/tb_booth_mult_seq.sv - directed and swept checks for booth_mult_seq
// Latency expectations follow BOOTH_RADIX4_EN when defined.
module tb_booth_mult_seq;
  localparam int N = 8;
`ifdef BOOTH_RADIX4_EN
  localparam int LAT = (N + 2) / 2;
`else
  localparam int LAT = N + 1;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           tc;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] y;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  booth_mult_seq #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .tc(tc), .out_valid(out_valid), .out_ready(out_ready), .y(y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction from IDLE: accept, count edges to out_valid, check y, drain.
  task automatic xact(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                      input logic tcv, input logic [2*N-1:0] exp);
    int n;
    a = av; b = bv; tc = tcv; in_valid = 1'b1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    check({tag, "_latency"}, n, LAT);
    check({tag, "_y"}, 32'(y), 32'(exp));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [2*N-1:0] held;
    longint ea, eb;
    logic [2*N-1:0] exp;
    int last_acc, n;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; tc = 1'b0; out_ready = 1'b0;
    #2;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_y", 32'(y), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    xact("s_3x-5", 8'h03, 8'hFB, 1'b1, 16'hFFF1);
    xact("s_min_min", 8'h80, 8'h80, 1'b1, 16'h4000);
    xact("s_min_max", 8'h80, 8'h7F, 1'b1, 16'hC080);
    xact("u_ff_ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    xact("u_80_02", 8'h80, 8'h02, 1'b0, 16'h0100);
    xact("s_zero_a", 8'h00, 8'h9C, 1'b1, 16'h0000);
    xact("u_zero_b", 8'hA5, 8'h00, 1'b0, 16'h0000);

    // Backpressure: result held, new operands refused.
    a = 8'h12; b = 8'h34; tc = 1'b0; in_valid = 1'b1;
    step();
    a = 8'h55; b = 8'h66; tc = 1'b1;
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    check("bp_latency", n, LAT);
    held = y;
    check("bp_y", 32'(y), 32'h03A8);
    for (int i = 0; i < 20; i++) begin
      step();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_y", 32'(y), 32'(held));
      check("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_y", 32'(y), 32'h03A8);

    // Reset four edges into CALC.
    a = 8'h11; b = 8'h22; tc = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_y", 32'(y), 32'd0);
    check("rst_mid_ready", 32'(in_ready), 32'd1);
    step();
    rst = 1'b0;
    step();
    xact("post_rst_7x6", 8'h07, 8'h06, 1'b1, 16'h002A);

    // Sweep with out_ready tied high; accepts must be evenly spaced.
    out_ready = 1'b1;
    in_valid = 1'b1;
    last_acc = -1;
    for (int k = 0; k < 1000; k++) begin
      n = 0;
      while (!in_ready && n < 40) begin
        step();
        n++;
      end
      a = 8'($urandom);
      b = 8'($urandom);
      tc = k[0];
      ea = tc ? longint'($signed(a)) : longint'(a);
      eb = tc ? longint'($signed(b)) : longint'(b);
      exp = 16'(ea * eb);
      if (last_acc >= 0) check("sweep_interval", cyc - last_acc, LAT + 2);
      last_acc = cyc;
      step();
      n = 0;
      while (!out_valid && n < 40) begin
        step();
        n++;
      end
      check("sweep_y", {16'(k), y}, {16'(k), exp});
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
Sequential Booth multiplier with its own control FSM and valid/ready handshakes on operand and result sides. It is parametrised in width and supports signed or unsigned operands per transaction. It replaces the externally sequenced multiplier datapath, so the surrounding logic no longer drives per-cycle control words. Radix-2 recoding by default; radix-4 recoding as a compile option.

Parameters:
N, 8, operand width in bits; N >= 2; N must be even when BOOTH_RADIX4_EN is defined.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  operands a, b, tc are valid
in_ready  output  1  block accepts operands (high only in IDLE)
a  input  N  multiplicand
b  input  N  multiplier
tc  input  1  1 = two's-complement operands, 0 = unsigned
out_valid  output  1  result y is valid
out_ready  input  1  consumer accepts y
y  output  2N  product, low 2N bits of exact result

Behaviour:
- Reset: clk and rst only; reset is asynchronous and active-high. Reset forces state IDLE, in_ready=1, out_valid=0, y=0, and clears all internal registers (multiplicand M, accumulator, Q, Q_-1, iteration counter).
- FSM states:
  - IDLE: in_ready=1. When in_valid&in_ready:
    - Capture M = ext(a) and Q = ext(b), each extended to W=N+1 bits. ext is sign-extension when tc=1 and zero-extension when tc=0.
    - Clear the accumulator (W+1 bits) and Q_-1.
    - Load counter = W; go to CALC.
  - CALC: in_ready=0, out_valid=0. Each cycle examines {Q[0],Q_-1}:
    - 01: acc += M
    - 10: acc -= M
    - 00 or 11: no operation
    - Then arithmetic right shift of {acc,Q,Q_-1} by 1 and decrement the counter.
    - When the counter reaches 0 after the update, go to DONE.
  - DONE: out_valid=1, and y holds the low 2N bits of {acc,Q}. y is stable while out_valid=1 and out_ready=0. On out_ready=1, go to IDLE next cycle, with out_valid=0 and y retained.
- Arithmetic width: the accumulator is one bit wider than M, so there is no overflow for any operand pair. This includes a=b=-2^(N-1) signed (product +2^(2N-2)). Unsigned full-scale products are also exact.
- Latency:
  - Accept edge = edge 0. CALC performs one iteration per edge.
  - Radix-2: out_valid rises after edge N+1 (9 edges for N=8).
  - Throughput: one product per N+3 cycles minimum, because IDLE is revisited for one cycle.
- Boundary conditions:
  - in_valid while not in IDLE: ignored (in_ready=0). Operands are sampled only at the accept edge; later changes to a, b and tc have no effect.
  - out_ready high outside DONE: no effect.
  - rst asserted mid-CALC or in DONE: immediate return to IDLE; the pending result is discarded; out_valid drops asynchronously.
  - a=0 or b=0: full iteration count still runs; y=0.

Optional Feature:
BOOTH_RADIX4_EN
- Defined: radix-4 (modified) Booth recoding.
  - Operands are extended to W=N+2 bits; the accumulator is W+1 bits.
  - Each CALC cycle examines {Q[1],Q[0],Q_-1} and adds 0, +M, +2M, -M or -2M, then arithmetically shifts by 2.
  - Counter loads W/2, so out_valid rises after edge W/2 (5 edges for N=8).
  - Results are bit-identical to radix-2 for all inputs.
- Undefined: radix-2 only as above. No radix-4 logic is synthesised.

Test Plan:
- N=8, tc=1, a=0x03, b=0xFB (3*-5) -> y=0xFFF1; out_valid first seen 9 edges after accept (5 with BOOTH_RADIX4_EN).
- tc=1, a=0x80, b=0x80 -> y=0x4000; tc=1, a=0x80, b=0x7F -> y=0xC080.
- tc=0, a=0xFF, b=0xFF -> y=0xFE01; tc=0, a=0x80, b=0x02 -> y=0x0100.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> y and out_valid constant and in_ready=0; a new in_valid with other operands is not accepted. Then raise out_ready -> IDLE next cycle, and in_ready=1.
- Reset mid-operation: assert rst 4 cycles into CALC -> out_valid=0, y=0, in_ready=1 immediately. The next transaction, a=0x07, b=0x06 (tc=1), gives y=0x002A.
- Randomised sweep of 1000 pairs, both tc values -> y equals the reference product mod 2^16. Back-to-back accepts occur exactly N+3 cycles apart with out_ready tied high.
